adder_tree_acc: RTL and testbench



---
 rtl/adder_tree_acc.sv | 168 ++++++++++++++++
 tb/tb_adder_tree_acc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree reducing NUM_ADDEND lanes per beat, followed by a NUM_BEAT accumulator.
// Optional feature: define ADDER_TREE_ACC_SAT_EN to saturate (instead of wrap) the narrowed result.
module adder_tree_acc #(
    parameter int unsigned NUM_ADDEND   = 64,
    parameter int unsigned ADDEND_WIDTH = 8,
    parameter int unsigned NUM_BEAT     = 12,
    parameter int unsigned REG_STRIDE   = 1,
    parameter int unsigned SUM_WIDTH    = 18
) (
    input  logic                                clk_p,
    input  logic                                rst_p,
    input  logic [ADDEND_WIDTH*NUM_ADDEND-1:0]  addend,
    input  logic                                addend_valid_n,
    input  logic                                clear,
    output logic [SUM_WIDTH-1:0]                sum,
    output logic                                sum_valid_n,
    output logic                                sum_sat,
    output logic                                busy
);

    localparam int unsigned L     = $clog2(NUM_ADDEND);
    localparam int unsigned BW    = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 0;
    localparam int unsigned FW    = ADDEND_WIDTH + L + BW;
    localparam int unsigned CW    = (BW > 0) ? BW : 1;
    localparam int unsigned IW    = ADDEND_WIDTH * NUM_ADDEND;
    localparam logic [CW-1:0] LAST = CW'(NUM_BEAT - 1);

    logic          accept;
    logic [IW-1:0] in_q;
    logic          in_vld;
    logic [L:0]    lvl_vld;

    assign accept = ~addend_valid_n & ~clear;

    // Input capture: the edge that accepts a beat
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            in_q   <= '0;
            in_vld <= 1'b0;
        end else begin
            in_vld <= accept;
            if (accept) in_q <= addend;
        end
    end

    // Tree levels; nodes carried at full width, upper bits are plain sign extension
    for (genvar l = 0; l <= L; l++) begin : gen_lvl
        localparam int unsigned N = NUM_ADDEND >> l;
        logic signed [FW-1:0] node [N];
        logic                 vld;

        if (l == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_ext
                assign node[i] = FW'($signed(in_q[i*ADDEND_WIDTH +: ADDEND_WIDTH]));
            end
            assign vld = in_vld;
        end else begin : g_add
            logic signed [FW-1:0] pair [N];
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign pair[i] = gen_lvl[l-1].node[2*i] + gen_lvl[l-1].node[2*i+1];
            end

            if (((l % REG_STRIDE) == 0) || (l == L)) begin : g_reg
                always_ff @(posedge clk_p or posedge rst_p) begin
                    if (rst_p) begin
                        vld <= 1'b0;
                        for (int unsigned i = 0; i < N; i++) node[i] <= '0;
                    end else begin
                        vld <= gen_lvl[l-1].vld & ~clear;
                        if (gen_lvl[l-1].vld) begin
                            for (int unsigned i = 0; i < N; i++) node[i] <= pair[i];
                        end
                    end
                end
            end else begin : g_comb
                assign node = pair;
                assign vld  = gen_lvl[l-1].vld;
            end
        end

        assign lvl_vld[l] = vld;
    end

    logic signed [FW-1:0] partial;
    logic signed [FW-1:0] total;
    logic signed [FW-1:0] acc;
    logic signed [FW-1:0] acc_d;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_d;
    logic [SUM_WIDTH-1:0] red;
    logic                 red_sat;
    logic [SUM_WIDTH-1:0] sum_d;
    logic                 sum_valid_n_d;
    logic                 sum_sat_d;
    logic                 busy_d;
    logic                 tree_vld;

    assign partial  = gen_lvl[L].node[0];
    assign tree_vld = lvl_vld[L];
    assign total    = acc + partial;

    // Narrow the full-width group total to the output width
`ifdef ADDER_TREE_ACC_SAT_EN
    localparam logic signed [FW-1:0] SMAX = {{(FW-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [FW-1:0] SMIN = ~SMAX;

    always_comb begin
        red     = total[SUM_WIDTH-1:0];
        red_sat = 1'b0;
        if (total > SMAX) begin
            red     = SMAX[SUM_WIDTH-1:0];
            red_sat = 1'b1;
        end else if (total < SMIN) begin
            red     = SMIN[SUM_WIDTH-1:0];
            red_sat = 1'b1;
        end
    end
`else
    always_comb begin
        red     = total[SUM_WIDTH-1:0];
        red_sat = 1'b0;
    end
`endif

    // Accumulator next state; clear wins over a coincident final partial
    always_comb begin
        acc_d         = acc;
        cnt_d         = cnt;
        sum_d         = sum;
        sum_valid_n_d = 1'b1;
        sum_sat_d     = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (tree_vld) begin
            if (cnt == LAST) begin
                sum_d         = red;
                sum_sat_d     = red_sat;
                sum_valid_n_d = 1'b0;
                acc_d         = '0;
                cnt_d         = '0;
            end else begin
                acc_d = total;
                cnt_d = cnt + CW'(1);
            end
        end
        busy_d = accept | (~clear & (|lvl_vld[L-1:0])) | (cnt_d != '0);
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            acc         <= '0;
            cnt         <= '0;
            sum         <= '0;
            sum_valid_n <= 1'b1;
            sum_sat     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            acc         <= acc_d;
            cnt         <= cnt_d;
            sum         <= sum_d;
            sum_valid_n <= sum_valid_n_d;
            sum_sat     <= sum_sat_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: table of beat groups with a result scoreboard, plus flush/reset/narrow-width sequences.
module tb_adder_tree_acc;

    localparam int unsigned NA = 64;
    localparam int unsigned AW = 8;
    localparam int unsigned NB = 12;

    logic                 clk_p = 1'b0;
    logic                 rst_p;
    logic                 clear;
    logic                 valid_n;
    logic                 valid_n_w;
    logic [NA*AW-1:0]     addend;
    logic signed [17:0]   sum;
    logic                 svn;
    logic                 sat;
    logic                 busy;
    logic signed [11:0]   sum_w;
    logic                 svn_w;
    logic                 sat_w;
    logic                 busy_w;

    adder_tree_acc dut (
        .clk_p(clk_p), .rst_p(rst_p), .addend(addend), .addend_valid_n(valid_n),
        .clear(clear), .sum(sum), .sum_valid_n(svn), .sum_sat(sat), .busy(busy)
    );

    adder_tree_acc #(.SUM_WIDTH(12)) dut_w (
        .clk_p(clk_p), .rst_p(rst_p), .addend(addend), .addend_valid_n(valid_n_w),
        .clear(clear), .sum(sum_w), .sum_valid_n(svn_w), .sum_sat(sat_w), .busy(busy_w)
    );

    always #5 clk_p = ~clk_p;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic signed [17:0] sum;
        logic               sat;
        int                 due;
    } exp_t;

    typedef struct {
        int val;
        bit ramp;
        bit rnd;
        bit gap;
        bit b2b;
        int exp;
    } grp_t;

    exp_t q[$];
    exp_t mon_e;
    grp_t tbl[7];

    always @(posedge clk_p) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest pending expectation
    always @(negedge clk_p) begin
        if (!rst_p && svn == 1'b0) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("sum", longint'(sum), longint'(mon_e.sum));
                chk("sum_sat", longint'(sat), longint'(mon_e.sat));
                chk("pulse_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic drive_beat(input logic [NA*AW-1:0] a, input bit wide);
        @(negedge clk_p); #1;
        addend    = a;
        clear     = 1'b0;
        valid_n   = ~wide;
        valid_n_w = wide;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_p); #1;
            valid_n   = 1'b1;
            valid_n_w = 1'b1;
            clear     = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        idle(1);
        while (q.size() != 0 && k < 60) begin
            idle(1);
            k++;
        end
        chk({name, "_drained"}, q.size(), 0);
        chk({name, "_busy_low"}, longint'(busy), 0);
        q.delete();
    endtask

    task automatic run_group(input grp_t g);
        logic [NA*AW-1:0] a;
        longint           s;
        int               v;
        exp_t             e;
        s = 0;
        for (int b = 0; b < NB; b++) begin
            if (b > 0 && g.gap) idle(1);
            for (int i = 0; i < NA; i++) begin
                if (g.rnd)       v = int'($urandom_range(0, 255)) - 128;
                else if (g.ramp) v = b + 1;
                else             v = g.val;
                a[i*AW +: AW] = AW'(v);
                s += v;
            end
            drive_beat(a, 1'b1);
            if (b == 1) chk("busy_mid", longint'(busy), 1);
            if (b == NB - 1) begin
                e.sum = g.rnd ? 18'(s) : 18'(g.exp);
                e.sat = 1'b0;
                e.due = cyc + 8;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NA*AW-1:0] a;
        int               d;
        int               k;
        bit               got;

        rst_p = 1'b1; clear = 1'b0; valid_n = 1'b1; valid_n_w = 1'b1; addend = '0;
        //           val   ramp rnd gap b2b exp
        tbl[0] = '{  1,    0,   0,  0,  0,  768};
        tbl[1] = '{ -128,  0,   0,  0,  0, -98304};
        tbl[2] = '{  0,    1,   0,  1,  0,  4992};
        tbl[3] = '{  1,    0,   0,  0,  1,  768};
        tbl[4] = '{  2,    0,   0,  0,  0,  1536};
        tbl[5] = '{  0,    0,   1,  0,  0,  0};
        tbl[6] = '{  0,    0,   1,  1,  0,  0};

        repeat (3) @(negedge clk_p);
        rst_p = 1'b0;
        @(negedge clk_p); #1;
        chk("rst_sum", longint'(sum), 0);
        chk("rst_valid_n", longint'(svn), 1);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_sum_w", longint'(sum_w), 0);

        for (int g = 0; g < 7; g++) begin
            run_group(tbl[g]);
            if (!tbl[g].b2b) wait_drain($sformatf("grp%0d", g));
        end

        // Narrow output: 97536 does not fit in 12 bits
        for (int i = 0; i < NA; i++) a[i*AW +: AW] = 8'sd127;
        d = 0;
        for (int b = 0; b < NB; b++) begin
            drive_beat(a, 1'b0);
            d = cyc;
        end
        @(negedge clk_p); #1;
        valid_n_w = 1'b1;
        got = 1'b0;
        k = 0;
        while (!got && k < 40) begin
            @(negedge clk_p);
            if (svn_w == 1'b0) got = 1'b1;
            else k++;
        end
        if (!got) begin
            chk("w_timeout", 1, 0);
        end else begin
            chk("w_latency", cyc - d, 8);
`ifdef ADDER_TREE_ACC_SAT_EN
            chk("w_sum", longint'(sum_w), 2047);
            chk("w_sat", longint'(sat_w), 1);
`else
            chk("w_sum", longint'(sum_w), -768);
            chk("w_sat", longint'(sat_w), 0);
`endif
        end
        idle(1);
        chk("w_busy_low", longint'(busy_w), 0);

        // Flush mid-group; the beat presented with clear is dropped
        for (int i = 0; i < NA; i++) a[i*AW +: AW] = 8'sd1;
        for (int b = 0; b < 5; b++) drive_beat(a, 1'b1);
        @(negedge clk_p); #1;
        clear = 1'b1; valid_n = 1'b0;
        @(negedge clk_p); #1;
        clear = 1'b0; valid_n = 1'b1;
        chk("flush_busy", longint'(busy), 0);
        run_group(tbl[0]);
        wait_drain("flush");

        // Reset mid-group discards the group and clears outputs immediately
        for (int i = 0; i < NA; i++) a[i*AW +: AW] = 8'sd3;
        for (int b = 0; b < 6; b++) drive_beat(a, 1'b1);
        @(negedge clk_p); #1;
        valid_n = 1'b1;
        chk("hold_sum", longint'(sum), 768);
        rst_p = 1'b1;
        #1;
        chk("midrst_sum", longint'(sum), 0);
        chk("midrst_valid_n", longint'(svn), 1);
        chk("midrst_busy", longint'(busy), 0);
        @(negedge clk_p);
        rst_p = 1'b0;
        idle(20);
        chk("post_rst_busy", longint'(busy), 0);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
